// File: rtl/axis_arb_mux_rr_pkg.sv
// axis_arb_mux_rr_pkg: arbiter FSM encoding and the clog2 used to size grant indices
package axis_arb_mux_rr_pkg;
  typedef enum logic {IDLE = 1'b0, ACTIVE = 1'b1} state_t;
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) if ((1 << i) < n) r = i + 1;
    return r;
  endfunction
endpackage

// File: rtl/axis_arb_mux_rr_select.sv
// rr_priority_select: combinational round-robin pick of the first requester after last_i (one-hot and index)
module rr_priority_select
  import axis_arb_mux_rr_pkg::*;
#(
  parameter int PORTS = 4,
  localparam int GW = clog2(PORTS)
) (
  input  logic [PORTS-1:0] req_i,
  input  logic [GW-1:0]    last_i,
  output logic             valid_o,
  output logic [PORTS-1:0] onehot_o,
  output logic [GW-1:0]    idx_o
);
  logic [GW-1:0] p;
  always_comb begin
    p = '0;
    idx_o = '0;
    valid_o = 1'b0;
    for (int k = 1; k <= PORTS; k++) begin
      p = GW'((int'(last_i) + k) % PORTS);
      if (!valid_o && req_i[p]) begin
        valid_o = 1'b1;
        idx_o = p;
      end
    end
    onehot_o = valid_o ? PORTS'(1) << idx_o : '0;
  end
endmodule

// File: rtl/axis_arb_mux_rr.sv
// axis_arb_mux_rr: packet-aware round-robin AXI-Stream mux with a registered 2-entry skid output
module axis_arb_mux_rr
  import axis_arb_mux_rr_pkg::*;
#(
  parameter int PORTS = 4,
  parameter int DATA_WIDTH = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [PORTS*DATA_WIDTH-1:0] input_axis_tdata,
  input  logic [PORTS-1:0]            input_axis_tvalid,
  output logic [PORTS-1:0]            input_axis_tready,
  input  logic [PORTS-1:0]            input_axis_tlast,
  input  logic [PORTS-1:0]            input_axis_tuser,
  output logic [DATA_WIDTH-1:0]       output_axis_tdata,
  output logic                        output_axis_tvalid,
  input  logic                        output_axis_tready,
  output logic                        output_axis_tlast,
  output logic                        output_axis_tuser
);
  localparam int GW = clog2(PORTS);
  state_t state_q, state_d;
  logic [GW-1:0] grant_q, grant_d, last_q, last_d, sel_idx;
  logic [PORTS-1:0] grant_oh_q, grant_oh_d, sel_oh;
  logic sel_valid, in_xfer;
  logic ready_int_q, ready_int_d;
  logic out_valid_q, out_valid_d, temp_valid_q, temp_valid_d;
  logic [DATA_WIDTH+1:0] out_q, out_d, temp_q, temp_d, in_beat;
  rr_priority_select #(.PORTS(PORTS)) u_sel (
    .req_i   (input_axis_tvalid),
    .last_i  (last_q),
    .valid_o (sel_valid),
    .onehot_o(sel_oh),
    .idx_o   (sel_idx)
  );
  assign in_beat = {input_axis_tdata[int'(grant_q)*DATA_WIDTH +: DATA_WIDTH], input_axis_tlast[grant_q],
                    input_axis_tuser[grant_q]};
  assign in_xfer = (state_q == ACTIVE) && input_axis_tvalid[grant_q] && ready_int_q;
  assign input_axis_tready = (state_q == ACTIVE && ready_int_q) ? grant_oh_q : '0;
  assign output_axis_tvalid = out_valid_q;
  assign {output_axis_tdata, output_axis_tlast, output_axis_tuser} = out_q;
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    grant_oh_d = grant_oh_q;
    last_d = last_q;
    if (state_q == IDLE && sel_valid) begin
      state_d = ACTIVE;
      grant_d = sel_idx;
      grant_oh_d = sel_oh;
      last_d = sel_idx;
    end else if (in_xfer && in_beat[1]) begin
      state_d = IDLE;
    end
  end
  // ready for next cycle is decided now, so the temp slot always has room for a beat accepted this cycle
  always_comb begin
    out_valid_d = out_valid_q;
    temp_valid_d = temp_valid_q;
    out_d = out_q;
    temp_d = temp_q;
    ready_int_d = output_axis_tready | (~temp_valid_q & (~out_valid_q | ~in_xfer));
    if (ready_int_q && (output_axis_tready || !out_valid_q)) begin
      out_valid_d = in_xfer;
      out_d = in_beat;
    end else if (ready_int_q) begin
      temp_valid_d = in_xfer;
      temp_d = in_beat;
    end else if (output_axis_tready) begin
      out_valid_d = temp_valid_q;
      temp_valid_d = 1'b0;
      out_d = temp_q;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      grant_oh_q <= PORTS'(1);
      last_q <= GW'(PORTS - 1);
      ready_int_q <= 1'b0;
      out_valid_q <= 1'b0;
      temp_valid_q <= 1'b0;
      out_q <= '0;
      temp_q <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      grant_oh_q <= grant_oh_d;
      last_q <= last_d;
      ready_int_q <= ready_int_d;
      out_valid_q <= out_valid_d;
      temp_valid_q <= temp_valid_d;
      out_q <= out_d;
      temp_q <= temp_d;
    end
  end
endmodule

// File: tb/tb_axis_arb_mux_rr.sv
// tb_axis_arb_mux_rr: directed and random checks of the round-robin packet mux against a scoreboard model
module tb_axis_arb_mux_rr;
  localparam int P = 4;
  localparam int W = 8;
  typedef struct packed {logic [W-1:0] d; logic l; logic u;} beat_t;
  logic clk = 1'b0, rst = 1'b0;
  logic [P*W-1:0] input_axis_tdata = '0;
  logic [P-1:0] input_axis_tvalid = '0, input_axis_tlast = '0, input_axis_tuser = '0, input_axis_tready;
  logic [W-1:0] output_axis_tdata;
  logic output_axis_tvalid, output_axis_tlast, output_axis_tuser, output_axis_tready = 1'b0;
  axis_arb_mux_rr #(.PORTS(P), .DATA_WIDTH(W)) dut (
    .clk               (clk),
    .rst               (rst),
    .input_axis_tdata  (input_axis_tdata),
    .input_axis_tvalid (input_axis_tvalid),
    .input_axis_tready (input_axis_tready),
    .input_axis_tlast  (input_axis_tlast),
    .input_axis_tuser  (input_axis_tuser),
    .output_axis_tdata (output_axis_tdata),
    .output_axis_tvalid(output_axis_tvalid),
    .output_axis_tready(output_axis_tready),
    .output_axis_tlast (output_axis_tlast),
    .output_axis_tuser (output_axis_tuser)
  );
  always #5 clk = ~clk;
  beat_t srcq[P][$];
  beat_t expq[$];
  beat_t ol_b[$];
  int ol_cyc[$];
  int seq[P];
  int ft[P];
  logic tr2[64];
  int vectors = 0, miscompares = 0;
  int cyc, last_port, cur, win;
  bit free, pend_free, want, lat_pend, pv, pr;
  beat_t pbeat, b, wb;
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask
  function automatic int rr(input int last, input logic [P-1:0] req);
    for (int k = 1; k <= P; k++) if (req[(last + k) % P]) return (last + k) % P;
    return -1;
  endfunction
  task automatic push_pkt(input int p, input int len);
    for (int i = 0; i < len; i++) begin
      srcq[p].push_back({2'(p), 6'(seq[p]), i == len - 1, 1'($urandom_range(0, 1))});
      seq[p]++;
    end
  endtask
  task automatic drive(input bit ordy);
    output_axis_tready = ordy;
    for (int p = 0; p < P; p++) begin
      input_axis_tvalid[p] = srcq[p].size() > 0;
      input_axis_tdata[p*W +: W] = (srcq[p].size() > 0) ? srcq[p][0].d : '0;
      input_axis_tlast[p] = (srcq[p].size() > 0) ? srcq[p][0].l : 1'b0;
      input_axis_tuser[p] = (srcq[p].size() > 0) ? srcq[p][0].u : 1'b0;
    end
  endtask
  task automatic tick(input bit ordy);
    @(negedge clk);
    drive(ordy);
  endtask
  task automatic rst_on();
    @(negedge clk);
    rst = 1'b1;
    for (int p = 0; p < P; p++) srcq[p].delete();
    drive(1'b1);
    @(negedge clk);
    @(negedge clk);
  endtask
  task automatic rst_off();
    @(negedge clk);
    rst = 1'b0;
    drive(1'b1);
  endtask
  // compare process: scoreboard plus arbitration/handshake rules, evaluated mid-cycle for the coming edge
  always @(negedge clk) begin
    #2;
    if (rst) begin
      chk("rst_out", {17'd0, output_axis_tvalid, output_axis_tdata, output_axis_tlast, output_axis_tuser,
          input_axis_tready}, 0);
      expq.delete();
      ol_b.delete();
      ol_cyc.delete();
      ft = '{default: -1};
      free = 1;
      pend_free = 0;
      want = 0;
      lat_pend = 0;
      pv = 0;
      last_port = P - 1;
      cur = -1;
      cyc = 0;
    end else begin
      if (pend_free) begin
        free = 1;
        pend_free = 0;
      end
      chk("tready_onehot", 32'($onehot0(input_axis_tready)), 1);
      if (pv && !pr)
        chk("out_hold", {21'd0, output_axis_tvalid, output_axis_tdata, output_axis_tlast, output_axis_tuser},
            {21'd0, 1'b1, pbeat});
      if (lat_pend) chk("latency", 32'(output_axis_tvalid), 1);
      lat_pend = 0;
      for (int p = 0; p < P; p++) if (input_axis_tready[p] && ft[p] < 0) ft[p] = cyc;
      if (cyc < 64) tr2[cyc] = input_axis_tready[2];
      if (free) begin
        chk("idle_tready", 32'(input_axis_tready), 0);
        if (|input_axis_tvalid) begin
          win = rr(last_port, input_axis_tvalid);
          last_port = win;
          free = 0;
          want = 1;
        end
      end
      for (int p = 0; p < P; p++) begin
        if (input_axis_tvalid[p] && input_axis_tready[p]) begin
          b = {input_axis_tdata[p*W +: W], input_axis_tlast[p], input_axis_tuser[p]};
          void'(srcq[p].pop_front());
          chk("grant_port", p, want ? win : cur);
          want = 0;
          cur = p;
          if (expq.size() == 0) lat_pend = 1;
          expq.push_back(b);
          if (b.l) begin
            pend_free = 1;
            cur = -1;
          end
        end
      end
      if (output_axis_tvalid && output_axis_tready) begin
        b = {output_axis_tdata, output_axis_tlast, output_axis_tuser};
        wb = (expq.size() > 0) ? expq.pop_front() : ~b;
        chk("out_beat", 32'(b), 32'(wb));
        ol_b.push_back(b);
        ol_cyc.push_back(cyc);
      end
      chk("buffer_depth", 32'(expq.size() <= 2), 1);
      pv = output_axis_tvalid;
      pr = output_axis_tready;
      pbeat = {output_axis_tdata, output_axis_tlast, output_axis_tuser};
      cyc++;
    end
  end
  initial begin
    int e3[8] = '{2, 3, 4, 10, 11, 12, 13, 14};
    int left;
    chk("rr_pin_a", rr(3, 4'b1111), 0);
    chk("rr_pin_b", rr(0, 4'b0101), 2);
    chk("rr_pin_c", rr(2, 4'b0011), 0);
    chk("rr_pin_d", rr(1, 4'b0010), 1);
    // 1: port 1 three-beat packet, sink always ready
    rst_on();
    push_pkt(1, 3);
    rst_off();
    repeat (8) tick(1'b1);
    chk("t1_first_tready", ft[1], 1);
    chk("t1_count", ol_cyc.size(), 3);
    for (int i = 0; i < 3; i++) begin
      chk("t1_cycle", ol_cyc[i], i + 2);
      chk("t1_port", 32'(ol_b[i].d[7:6]), 1);
      chk("t1_last", 32'(ol_b[i].l), 32'(i == 2));
    end
    chk("t1_drain", expq.size(), 0);
    // 2: all ports hold single-beat packets
    rst_on();
    for (int p = 0; p < P; p++) begin
      push_pkt(p, 1);
      push_pkt(p, 1);
    end
    rst_off();
    repeat (20) tick(1'b1);
    for (int i = 0; i < 6; i++) begin
      chk("t2_port", 32'(ol_b[i].d[7:6]), i % 4);
      chk("t2_cycle", ol_cyc[i], 2 + 2 * i);
    end
    chk("t2_drain", expq.size(), 0);
    // 3: port 2 eight beats, sink stalls for 5 cycles with beat 3 on the output
    rst_on();
    push_pkt(2, 8);
    rst_off();
    for (int c = 1; c <= 20; c++) tick(!(c >= 5 && c <= 9));
    chk("t3_tready_c5", 32'(tr2[5]), 1);
    chk("t3_tready_c6", 32'(tr2[6]), 0);
    chk("t3_count", ol_cyc.size(), 8);
    for (int i = 0; i < 8; i++) begin
      chk("t3_cycle", ol_cyc[i], e3[i]);
      chk("t3_last", 32'(ol_b[i].l), 32'(i == 7));
    end
    chk("t3_drain", expq.size(), 0);
    // 4: port 0 requests while port 2 is mid-packet
    rst_on();
    push_pkt(2, 4);
    rst_off();
    tick(1'b1);
    push_pkt(0, 1);
    repeat (10) tick(1'b1);
    chk("t4_port0_tready", ft[0], 6);
    chk("t4_p2_last_port", 32'(ol_b[3].d[7:6]), 2);
    chk("t4_p0_port", 32'(ol_b[4].d[7:6]), 0);
    chk("t4_p0_cycle", ol_cyc[4], 7);
    chk("t4_drain", expq.size(), 0);
    // 5: reset during beat 2 of a port 3 packet
    rst_on();
    push_pkt(3, 6);
    rst_off();
    tick(1'b1);
    tick(1'b1);
    rst_on();
    push_pkt(3, 2);
    push_pkt(0, 1);
    rst_off();
    repeat (12) tick(1'b1);
    chk("t5_p0_tready", ft[0], 1);
    chk("t5_p3_tready", ft[3], 3);
    chk("t5_first_cycle", ol_cyc[0], 2);
    chk("t5_first_port", 32'(ol_b[0].d[7:6]), 0);
    chk("t5_drain", expq.size(), 0);
    // 6: random packets on ports 0,1,3 with a 50% sink
    rst_on();
    rst_off();
    for (int c = 0; c < 10000; c++) begin
      for (int p = 0; p < P; p++) if (p != 2 && srcq[p].size() < 3) push_pkt(p, $urandom_range(1, 5));
      tick(1'($urandom_range(0, 1)));
    end
    repeat (300) tick(1'b1);
    left = expq.size();
    for (int p = 0; p < P; p++) left += srcq[p].size();
    chk("t6_drain", left, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
